// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse handshake transmitter.
package pulse_hs_pkg;

    localparam int unsigned PULSE_HS_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_e;

endpackage

// File: rtl/pulse_hs_tx_sync.sv
// N-stage flop synchroniser with synchronous active-high reset.
module sync_chain_srst
    import pulse_hs_pkg::*;
#(
    parameter int unsigned STAGES = PULSE_HS_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pulse_hs_tx.sv
// Two-phase handshake sender: queues local pulses, launches one req toggle per event.
// Optional WAIT_ACK timeout flag built with `define PULSE_HS_TX_TIMEOUT_EN.
module pulse_hs_tx
    import pulse_hs_pkg::*;
#(
    parameter int unsigned NUM_SYNC_STAGES = PULSE_HS_SYNC_STAGES,
    parameter int unsigned CNT_W           = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_tggl_in,
    output logic             req_tggl,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovrflw,
    output logic             timeout_err
);

    localparam logic [0:0]       S_IDLE  = 1'(IDLE);
    localparam logic [0:0]       S_WAIT  = 1'(WAIT_ACK);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (NUM_SYNC_STAGES < 2) begin : g_bad_sync
        $error("NUM_SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             launch;
    logic             ack_s;
    logic             ack_match;
    logic [CNT_W-1:0] pend_nxt;
    logic             ovrflw_nxt;

    sync_chain_srst #(
        .STAGES (NUM_SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_tggl_in),
        .q   (ack_s)
    );

    assign ack_match = (ack_s == req_tggl);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Launch only from IDLE, so the WAIT_ACK exit cycle never launches.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            S_IDLE: begin
                if ((pend_cnt != '0) || pulse_in) begin
                    launch    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_match) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pending count: +pulse -launch, saturating at full with a drop pulse.
    always_comb begin
        pend_nxt   = pend_cnt;
        ovrflw_nxt = 1'b0;
        if (pulse_in && !launch) begin
            if (pend_cnt == CNT_MAX) begin
                ovrflw_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + CNT_W'(1);
            end
        end else if (!pulse_in && launch) begin
            pend_nxt = pend_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_tggl <= 1'b0;
            pend_cnt <= '0;
            ovrflw   <= 1'b0;
        end else begin
            req_tggl <= req_tggl ^ launch;
            pend_cnt <= pend_nxt;
            ovrflw   <= ovrflw_nxt;
        end
    end

    assign busy = (state == S_WAIT) || (pend_cnt != '0);

`ifdef PULSE_HS_TX_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Flag is sticky; the FSM keeps waiting so no toggle is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (launch) begin
                to_cnt <= '0;
            end else if ((state == S_WAIT) && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if ((state == S_WAIT) && !ack_match && (to_cnt == TO_LAST)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
